// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit/receive support blocks.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } feeder_state_t;

  // Even parity of one byte; lets the RX side share the same helper.
  function automatic logic byte_parity(input logic [UART_BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with synchronous flush; dout always shows the head entry.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = UART_BYTE_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;

  assign full_s  = (count_r == (AW+1)'(DEPTH));
  assign empty_s = (count_r == {(AW+1){1'b0}});
  // A flush in the same cycle discards the incoming write.
  assign push_s  = wr_en && !full_s && !flush;
  assign pop_s   = pop && !empty_s;

  // Storage write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = full_s;
  assign empty = empty_s;

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte buffer in front of the uart core: queues host bytes and launches them
// one at a time, handshaking on the core's tx_done idle level.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [UART_BYTE_W-1:0] wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic                   flush,
  output logic [UART_BYTE_W-1:0] tx_data,
  output logic                   start_tx,
  input  logic                   tx_done,
  output logic [AW:0]            count,
  output logic                   empty,
  output logic                   busy,
  output logic                   byte_sent
);

  feeder_state_t          state_r;
  feeder_state_t          state_next_s;
  logic [UART_BYTE_W-1:0] head_s;
  logic [UART_BYTE_W-1:0] tx_data_r;
  logic                   start_tx_r;
  logic                   busy_r;
  logic                   byte_sent_r;
  logic                   pop_s;
  logic                   frame_end_s;
  logic                   full_s;
  logic                   empty_s;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_valid),
    .wr_data (wr_data),
    .pop     (pop_s),
    .flush   (flush),
    .dout    (head_s),
    .count   (count),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Launch sequencing: pop in IDLE, wait for the core to leave idle, then
  // wait for it to return to idle.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    frame_end_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s        = 1'b1;
          state_next_s = REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        if (!tx_done) begin
          state_next_s = BUSY;
        end else begin
          state_next_s = REQ;
        end
      end
      BUSY: begin
        if (tx_done) begin
          frame_end_s  = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = BUSY;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State and output registers; outputs are decoded from the next state so
  // they line up with the state register without any path from tx_done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      tx_data_r   <= {UART_BYTE_W{1'b0}};
      start_tx_r  <= 1'b0;
      busy_r      <= 1'b0;
      byte_sent_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      start_tx_r  <= (state_next_s == REQ);
      busy_r      <= (state_next_s != IDLE);
      byte_sent_r <= frame_end_s;
      // The core shifts tx_data bit by bit, so it only changes on a pop.
      if (pop_s) begin
        tx_data_r <= head_s;
      end else begin
        tx_data_r <= tx_data_r;
      end
    end
  end

  assign wr_ready  = !full_s;
  assign empty     = empty_s;
  assign tx_data   = tx_data_r;
  assign start_tx  = start_tx_r;
  assign busy      = busy_r;
  assign byte_sent = byte_sent_r;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a manual tx_done driver and a small
// behavioural 8N1 core model for the integrated scenario.
module tb_uart_tx_feeder;

  localparam int BIT_CLKS = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       flush;
  logic [7:0] tx_data;
  logic       start_tx;
  logic       tx_done;
  logic [4:0] count;
  logic       empty;
  logic       busy;
  logic       byte_sent;

  logic       man_done;
  logic       model_en;
  logic       m_done;
  int         m_phase;
  logic [7:0] m_byte;
  logic [7:0] frames_q [$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign tx_done = model_en ? m_done : man_done;

  uart_tx_feeder #(.DEPTH(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .flush     (flush),
    .tx_data   (tx_data),
    .start_tx  (start_tx),
    .tx_done   (tx_done),
    .count     (count),
    .empty     (empty),
    .busy      (busy),
    .byte_sent (byte_sent)
  );

  // Behavioural core: leaves idle one edge after seeing start_tx, samples
  // tx_data at the start of each data bit, frames start+8+stop bits.
  always @(posedge clk) begin
    if (!reset_n || !model_en) begin
      m_done  <= 1'b1;
      m_phase <= 0;
    end else if (m_done) begin
      if (start_tx) begin
        m_done  <= 1'b0;
        m_phase <= 0;
      end
    end else begin
      if ((m_phase % BIT_CLKS) == 0 && (m_phase / BIT_CLKS) >= 1 && (m_phase / BIT_CLKS) <= 8)
        m_byte <= {tx_data[3'((m_phase / BIT_CLKS) - 1)], m_byte[7:1]};
      if (m_phase == 10 * BIT_CLKS - 1) begin
        m_done <= 1'b1;
        frames_q.push_back(m_byte);
      end else begin
        m_phase <= m_phase + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  // Waits for a launch, checks the byte, then plays one short frame.
  task automatic drain_one(input logic [7:0] exp);
    int n = 0;
    while (start_tx !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("launch_seen", {31'd0, start_tx}, 32'd1);
    chk("drain_data", {24'd0, tx_data}, {24'd0, exp});
    man_done = 1'b0;
    tick();
    chk("drain_req_drop", {31'd0, start_tx}, 32'd0);
    man_done = 1'b1;
    tick();
    chk("drain_byte_sent", {31'd0, byte_sent}, 32'd1);
  endtask

  initial begin
    logic stable;
    logic saw_start;
    int   pulses;

    reset_n  = 1'b0;
    wr_data  = 8'h00;
    wr_valid = 1'b0;
    flush    = 1'b0;
    man_done = 1'b1;
    model_en = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    chk("rst_tx_data", {24'd0, tx_data}, 32'h00);
    chk("rst_start_tx", {31'd0, start_tx}, 32'd0);
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_byte_sent", {31'd0, byte_sent}, 32'd0);

    // Single byte A5
    wr(8'hA5);
    chk("s_count1", {27'd0, count}, 32'd1);
    chk("s_empty0", {31'd0, empty}, 32'd0);
    chk("s_start_before_load", {31'd0, start_tx}, 32'd0);
    tick();
    chk("s_start_tx", {31'd0, start_tx}, 32'd1);
    chk("s_tx_data", {24'd0, tx_data}, 32'hA5);
    chk("s_count0", {27'd0, count}, 32'd0);
    chk("s_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("s_req_hold1", {31'd0, start_tx}, 32'd1);
    tick();
    chk("s_req_hold2", {31'd0, start_tx}, 32'd1);
    man_done = 1'b0;
    tick();
    chk("s_req_drop", {31'd0, start_tx}, 32'd0);
    stable = 1'b1;
    for (int i = 0; i < 19; i++) begin
      if (tx_data !== 8'hA5 || start_tx !== 1'b0 || byte_sent !== 1'b0 || busy !== 1'b1)
        stable = 1'b0;
      tick();
    end
    chk("s_busy_stable", {31'd0, stable}, 32'd1);
    man_done = 1'b1;
    tick();
    chk("s_byte_sent", {31'd0, byte_sent}, 32'd1);
    chk("s_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("s_pulse_once", {31'd0, byte_sent}, 32'd0);
    chk("s_no_relaunch", {31'd0, start_tx}, 32'd0);
    chk("s_count_end", {27'd0, count}, 32'd0);

    // Fill to full while the core stays busy
    man_done = 1'b0;
    for (int i = 0; i < 16; i++) wr(8'h10 + 8'(i));
    chk("f_count15", {27'd0, count}, 32'd15);
    chk("f_first_byte", {24'd0, tx_data}, 32'h10);
    chk("f_ready_15", {31'd0, wr_ready}, 32'd1);
    wr(8'h20);
    chk("f_count16", {27'd0, count}, 32'd16);
    chk("f_full_ready", {31'd0, wr_ready}, 32'd0);
    wr_data  = 8'h21;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    chk("f_refused", {27'd0, count}, 32'd16);
    man_done = 1'b1;
    tick();
    chk("f_first_sent", {31'd0, byte_sent}, 32'd1);
    for (int i = 1; i <= 16; i++) drain_one(8'h10 + 8'(i));
    chk("f_drained", {27'd0, count}, 32'd0);
    chk("f_empty", {31'd0, empty}, 32'd1);

    // Simultaneous push and pop at count 5
    man_done = 1'b0;
    for (int i = 0; i < 6; i++) wr(8'h30 + 8'(i));
    chk("p_count5", {27'd0, count}, 32'd5);
    man_done = 1'b1;
    tick();
    chk("p_sent30", {31'd0, byte_sent}, 32'd1);
    wr(8'h36);
    chk("p_count_same", {27'd0, count}, 32'd5);
    chk("p_popped31", {24'd0, tx_data}, 32'h31);
    for (int i = 1; i <= 6; i++) drain_one(8'h30 + 8'(i));
    chk("p_drained", {27'd0, count}, 32'd0);

    // Flush during BUSY with 4 queued
    man_done = 1'b0;
    for (int i = 0; i < 5; i++) wr(8'h40 + 8'(i));
    chk("x_count4", {27'd0, count}, 32'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("x_count0", {27'd0, count}, 32'd0);
    chk("x_empty", {31'd0, empty}, 32'd1);
    chk("x_inflight", {31'd0, busy}, 32'd1);
    chk("x_data_held", {24'd0, tx_data}, 32'h40);
    man_done = 1'b1;
    tick();
    chk("x_byte_sent", {31'd0, byte_sent}, 32'd1);
    saw_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (start_tx !== 1'b0) saw_start = 1'b1;
    end
    chk("x_no_start", {31'd0, saw_start}, 32'd0);

    // Reset asserted in REQ
    wr(8'h50);
    wr(8'h51);
    chk("r_in_req", {31'd0, start_tx}, 32'd1);
    chk("r_count1", {27'd0, count}, 32'd1);
    reset_n = 1'b0;
    #2;
    chk("r_start_tx", {31'd0, start_tx}, 32'd0);
    chk("r_tx_data", {24'd0, tx_data}, 32'h00);
    chk("r_count", {27'd0, count}, 32'd0);
    chk("r_empty", {31'd0, empty}, 32'd1);
    chk("r_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("r_busy", {31'd0, busy}, 32'd0);
    chk("r_byte_sent", {31'd0, byte_sent}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    wr(8'h52);
    drain_one(8'h52);
    chk("r_count_end", {27'd0, count}, 32'd0);

    // Integrated with a behavioural 8N1 core
    tick();
    model_en = 1'b1;
    tick();
    wr(8'h55);
    wr(8'h0F);
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      if (byte_sent === 1'b1) pulses++;
      tick();
    end
    chk("u_pulses", pulses, 32'd2);
    chk("u_frames", frames_q.size(), 32'd2);
    if (frames_q.size() >= 2) begin
      chk("u_frame0", {24'd0, frames_q[0]}, 32'h55);
      chk("u_frame1", {24'd0, frames_q[1]}, 32'h0F);
    end
    chk("u_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Transmit-side byte buffer that sits directly upstream of the `uart` core. It accepts bytes from the host over a valid/ready interface, stores them in a FIFO, and presents them one at a time to the core's `tx_data`/`start_tx` inputs. It observes the core's `tx_done` level so that each byte is launched exactly once and `tx_data` stays stable for the whole frame.

## Interface
- `DEPTH`, 16: FIFO entries. Must be a power of two, ≥2.
- `AW`, $clog2(DEPTH): pointer width. Derived; do not override.

- `clk`  in  1  system clock; same clock as `uart`.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_data`  in  8  host byte.
- `wr_valid`  in  1  host byte valid.
- `wr_ready`  out  1  FIFO can accept; equals `count < DEPTH`.
- `flush`  in  1  synchronous clear of queued, not-yet-launched bytes.
- `tx_data`  out  8  to `uart.tx_data`; registered copy of the byte in flight.
- `start_tx`  out  1  to `uart.start_tx`; launch request.
- `tx_done`  in  1  from `uart.tx_done`; high = core idle.
- `count`  out  AW+1  number of bytes queued, excluding the byte in flight.
- `empty`  out  1  `count == 0`.
- `busy`  out  1  a byte is in flight (state ≠ IDLE).
- `byte_sent`  out  1  one-cycle pulse when the in-flight frame completes.

## Operation
- Write: on a posedge with `wr_valid && wr_ready`, store `wr_data` at `wr_ptr`, then `wr_ptr++` (wraps mod DEPTH).
  - When full, `wr_ready=0` and the write is not taken; the host holds the byte.
  - Writes and bypass are never combined: a byte always passes through the FIFO.
- FSM states (enum `feeder_state_t`):
  - IDLE: `start_tx=0`. If `!empty`, then:
    - load `tx_data <= mem[rd_ptr]`, pop (`rd_ptr++`, `count--`);
    - go to REQ.
  - REQ: `start_tx=1`. Stay until `tx_done==0`, which means the core has left idle (this needs a `clk_tx` tick and `cts_n` low). Then go to BUSY.
  - BUSY: `start_tx=0`. Stay until `tx_done==1`, then pulse `byte_sent` and go to IDLE.
- `tx_data` changes only on the IDLE→REQ transition. It is held through REQ and BUSY because the core samples it bit by bit.
- Same-cycle push and pop: `count` is unchanged, both pointers advance, and the pushed byte lands correctly.
- `flush`:
  - Clears both pointers and `count` on the next edge; a write in that same cycle is dropped.
  - The in-flight byte (REQ/BUSY) completes normally.
  - If `flush` coincides with an IDLE pop, the pop still happens and that byte is launched.
- Reset mid-frame: everything returns to reset values immediately. Recovering the core is its own reset's job, since it shares `reset_n`.

## Timing
- Reset values:
  - `tx_data=8'h00`, `start_tx=0`, `count=0`, `empty=1`, `wr_ready=1`, `busy=0`, `byte_sent=0`.
  - State IDLE, pointers 0.
  - FIFO memory is not reset.
- Write at edge N: `count` and `empty` update at N. The FSM sees non-empty in the cycle after N and loads at edge N+1. `start_tx` is high from N+1.
- `start_tx` is a registered state decode with no combinational path from `tx_done`.
- `tx_done` is assumed synchronous to `clk`.
- Back-to-back bytes: BUSY→IDLE, then IDLE→REQ on the next edge. Minimum gap between frames is 2 `clk` cycles, plus the core's `clk_tx` alignment.
- `byte_sent` is high for exactly the one cycle after the edge on which BUSY→IDLE.

## Structure
- `uart_pkg`: `feeder_state_t` (IDLE, REQ, BUSY), `UART_BYTE_W = 8`.
- Sub-module `uart_sync_fifo`: a parameterised single-clock FIFO.
  - Ports: write, pop, flush, `dout = mem[rd_ptr]`, `count`, `full`, `empty`.
  - The uart RX side will reuse it.
- `uart_tx_feeder` holds the FSM and the `tx_data` register, and instantiates `uart_sync_fifo`.

## Test plan
- Single byte: write 8'hA5 with a `tx_done` model that drops 3 cycles after `start_tx` and rises 20 cycles later. Required: `tx_data=A5` stable throughout, `start_tx` high exactly until `tx_done` falls, one `byte_sent` pulse, `count` back to 0.
- Fill to full: 16 writes with `tx_done` held at 0 (core busy). Required: `count=15` and `tx_data=` first byte once it has been popped; a 17th byte is accepted only after one pop. Drain order matches write order.
- Simultaneous push and pop at `count=5`: `count` stays 5 and the byte sequence is preserved.
- Flush during BUSY with 4 queued: `count→0`, the in-flight byte still completes with `byte_sent`, and no further `start_tx` follows.
- Reset asserted in REQ: all outputs return to reset values asynchronously; after release, a new write launches normally.
- Integrated with `uart` (8N1, `cts_n=0`): send 8'h55 and 8'h0F back-to-back. Required: each byte is framed exactly once on `tx` and `byte_sent` fires twice.
